// File: rtl/px_router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | px_router_pkg : shared state type, source indices and width helper
// | Revision      : 1.0
// +----------------------------------------------------------------------------
package px_router_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam int SRC_SPI  = 0;
    localparam int SRC_LFSR = 1;

    // Index width for a count of items, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/px_path_router_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | px_path_router_if : source, core and SPI-reader signals of the router
// | Revision          : 1.0
// +----------------------------------------------------------------------------
interface px_path_router_if
    import px_router_pkg::*;
#(
    parameter int PX_WIDTH = 24,
    parameter int N_SRC    = 2,
    parameter int CNT_W    = 8
);
    localparam int MODE_W = clog2_min1(N_SRC);

    logic [MODE_W-1:0]         mode_i;
    logic                      bypass_i;
    logic [N_SRC*PX_WIDTH-1:0] src_px_i;
    logic [N_SRC-1:0]          src_rdy_i;
    logic [PX_WIDTH-1:0]       proc_px_o;
    logic                      proc_rdy_o;
    logic [PX_WIDTH-1:0]       proc_px_i;
    logic                      proc_rdy_i;
    logic [PX_WIDTH-1:0]       out_px_o;
    logic                      out_rdy_o;
    logic                      out_ack_i;
    logic [MODE_W-1:0]         active_mode_o;
    logic                      busy_o;
    logic [CNT_W-1:0]          drop_cnt_o;

    modport slave (
        input  mode_i, bypass_i, src_px_i, src_rdy_i, proc_px_i, proc_rdy_i, out_ack_i,
        output proc_px_o, proc_rdy_o, out_px_o, out_rdy_o, active_mode_o, busy_o, drop_cnt_o
    );

    modport master (
        output mode_i, bypass_i, src_px_i, src_rdy_i, proc_px_i, proc_rdy_i, out_ack_i,
        input  proc_px_o, proc_rdy_o, out_px_o, out_rdy_o, active_mode_o, busy_o, drop_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/px_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | px_fifo  : synchronous show-ahead result FIFO with occupancy count
// | Revision : 1.0
// +----------------------------------------------------------------------------
module px_fifo #(
    parameter int PX_WIDTH   = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk_i,
    input  wire logic                          nreset_i,
    input  wire logic                          push,
    input  wire logic [PX_WIDTH-1:0]           push_data,
    input  wire logic                          pop,
    output logic      [PX_WIDTH-1:0]           head,
    output logic      [$clog2(FIFO_DEPTH):0]   count,
    output logic                               full,
    output logic                               empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [PX_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic                do_pop;
    logic                do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/px_path_router.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | px_path_router : registered source/core/FIFO router with drain-safe switch
// | Revision       : 1.0
// +----------------------------------------------------------------------------
module px_path_router
    import px_router_pkg::*;
#(
    parameter int PX_WIDTH   = 24,
    parameter int N_SRC      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input wire logic         clk_i,
    input wire logic         nreset_i,
    px_path_router_if.slave  bus
);
    localparam int MODE_W = clog2_min1(N_SRC);
    localparam int MW1    = MODE_W + 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int SW     = CW + 1;
    localparam int DW     = CNT_W + 1;

    state_t              state;
    state_t              state_nxt;
    logic [MODE_W-1:0]   active_mode;
    logic [PX_WIDTH-1:0] stage_px;
    logic                stage_vld;
    logic                stage_byp;
    logic [CW-1:0]       outstanding;
    logic [CNT_W-1:0]    drop_cnt;

    logic                run_en;
    logic                busy;
    logic                mode_latch;
    logic                mode_valid;
    logic [PX_WIDTH-1:0] src_px_sel;
    logic                src_pulse;
    logic                credit_ok;
    logic                accept;
    logic                reject;
    logic                byp_push;
    logic                byp_drop;
    logic                fifo_push;
    logic                fifo_drop;
    logic [PX_WIDTH-1:0] fifo_wdata;
    logic [PX_WIDTH-1:0] fifo_head;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drained;
    logic [DW-1:0]       drop_sum;

    generate
        if (N_SRC == (1 << MODE_W)) begin : g_mode_full
            assign mode_valid = 1'b1;
        end else begin : g_mode_range
            assign mode_valid = ({1'b0, bus.mode_i} < MW1'(N_SRC));
        end
    endgenerate

    always_comb begin
        src_px_sel = '0;
        src_pulse  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (active_mode == MODE_W'(k)) begin
                src_px_sel = bus.src_px_i[k*PX_WIDTH +: PX_WIDTH];
                src_pulse  = bus.src_rdy_i[k];
            end
        end
    end

    // A bypass pixel still sitting in the stage register already owns a FIFO slot.
    assign credit_ok = (SW'(fifo_count) + SW'(outstanding) + SW'(stage_vld & stage_byp))
                       < SW'(FIFO_DEPTH);
    assign accept    = run_en & src_pulse & credit_ok;
    assign reject    = run_en & src_pulse & ~credit_ok;

    assign byp_push   = stage_vld & stage_byp & ~bus.proc_rdy_i;
    assign byp_drop   = stage_vld & stage_byp & bus.proc_rdy_i;
    assign fifo_push  = bus.proc_rdy_i | byp_push;
    assign fifo_wdata = bus.proc_rdy_i ? bus.proc_px_i : stage_px;
    assign fifo_drop  = fifo_push & fifo_full & ~bus.out_ack_i;
    assign drained    = (outstanding == '0) & fifo_empty & ~stage_vld;

    assign drop_sum = {1'b0, drop_cnt} + DW'(reject) + DW'(byp_drop) + DW'(fifo_drop);

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            stage_vld   <= 1'b0;
            stage_byp   <= 1'b0;
            stage_px    <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            active_mode <= MODE_W'(SRC_SPI);
        end else begin
            stage_vld <= accept;
            if (accept) begin
                stage_px  <= src_px_sel;
                stage_byp <= bus.bypass_i;
            end
            outstanding <= outstanding + CW'(accept & ~bus.bypass_i)
                                       - CW'(bus.proc_rdy_i & (outstanding != '0));
            drop_cnt    <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            if (mode_latch && mode_valid) active_mode <= bus.mode_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) state <= RUN;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (mode_valid && (bus.mode_i != active_mode)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (bus.mode_i == active_mode)   state_nxt = RUN;
                else if (drained && mode_valid)  state_nxt = SWITCH;
            end
            SWITCH:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        run_en     = 1'b0;
        busy       = 1'b0;
        mode_latch = 1'b0;
        case (state)
            RUN:     run_en     = 1'b1;
            DRAIN:   busy       = 1'b1;
            SWITCH:  mode_latch = 1'b1;
            default: ;
        endcase
    end

    px_fifo #(
        .PX_WIDTH   (PX_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .nreset_i  (nreset_i),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (bus.out_ack_i),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.proc_px_o     = stage_px;
    assign bus.proc_rdy_o    = stage_vld & ~stage_byp;
    assign bus.out_px_o      = fifo_head;
    assign bus.out_rdy_o     = ~fifo_empty;
    assign bus.active_mode_o = active_mode;
    assign bus.busy_o        = busy;
    assign bus.drop_cnt_o    = drop_cnt;

endmodule
`default_nettype wire
